huff_stream_front: RTL and testbench
====================================

# huff_stream_front

Parametrised bit-stream front end for the Huffman decode path. Accepts MSB-aligned code words of configurable width and valid length through a valid/ready handshake, buffers them in a small FIFO, serialises them at one bit per cycle, and decodes a fixed 16-symbol prefix code into 4-bit symbols with output backpressure. Codes may span word boundaries. The block supersedes the fixed 32-bit, no-backpressure serialiser-plus-decoder pairing.

## Interface

- `WORD_W`, 32: input word width in bits; must be ≥4.
- `FIFO_DEPTH`, 4: input word FIFO depth; power of two, ≥2.
- `LEN_W` is a derived localparam: `$clog2(WORD_W+1)`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WORD_W  code bits, MSB-aligned; first code bit is `in_data[WORD_W-1]`.
- `in_len`  in  LEN_W  number of valid bits in `in_data`; values above WORD_W are clamped to WORD_W.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  FIFO can accept a word.
- `out_sym`  out  4  decoded symbol.
- `out_valid`  out  1  `out_sym` valid.
- `out_ready`  in  1  consumer accepts the symbol.
- `fifo_level`  out  LEN_W  words currently in the FIFO, 0..FIFO_DEPTH.
- `busy`  out  1  any word, bit or partial code still in flight.
- `sym_count`  out  16  symbols delivered; present only with HUFF_FRONT_STATS_EN.

## Operation

- **Prefix code**, 3, 4 or 5 bits, first bit on the left:
  - `0ab` gives symbol `ab` (0–3).
  - `10ab` gives 4 + `ab` (4–7).
  - `11abc` gives 8 + `abc` (8–15).
- **FIFO**
  - Push on `in_valid && in_ready`.
  - `in_ready = (fifo_level != FIFO_DEPTH)`; no push while full, even if a pop occurs in the same cycle.
  - Word and clamped length are stored together.
- **Serialiser**
  - Holds one word plus a remaining-bit counter.
  - Loads the FIFO head when it is empty, or at the same edge its last bit is consumed (no bubble between words).
  - A head with length 0 is popped and discarded with no bit emitted; this takes one cycle.
- **Bit consumption**
  - One bit per cycle when the serialiser holds bits and the output register is free: `!out_valid || out_ready`.
  - Otherwise the bit stream stalls and state is held.
- **Decoder**
  - Accumulates bits into a 5-bit shift register with a 3-bit count.
  - A code completes on its 3rd bit (first bit 0), its 4th bit (prefix `10`) or its 5th bit (prefix `11`).
  - On completion: load `out_sym`, set `out_valid`, clear the accumulator.
  - A partial code persists across word boundaries and across FIFO-empty gaps indefinitely.
- **Output register**
  - `out_valid` clears on `out_ready` unless a new symbol completes in the same cycle.
  - `out_sym` is stable while `out_valid && !out_ready`.
- **`busy`** = FIFO non-empty, or serialiser bits remaining, or accumulator count ≠ 0, or `out_valid`.
- **Reset** (any time, including mid-code):
  - FIFO empty, serialiser empty, accumulator cleared.
  - `out_valid=0`, `out_sym=0`, `fifo_level=0`, `busy=0`, `sym_count=0`.
  - `in_ready=0` while `rst` is high, 1 after release.
  - The next word decodes from a fresh code boundary.

## Timing

- Latency, empty pipeline: handshake in cycle 0; FIFO write at end of cycle 0; serialiser load at end of cycle 1; bits consumed in cycles 2..(1+L) for an L-bit code. `out_valid` is high in cycle 2+L, so 5 cycles for a 3-bit code.
- Sustained throughput: 1 bit/cycle with `out_ready` held high; one symbol per 3–5 cycles.
- The final bit of a code may be consumed in the same cycle `out_ready` retires the previous symbol.
- `fifo_level` reflects pushes and pops at the edge following the handshake.

## Configuration

- `HUFF_FRONT_STATS_EN` defined:
  - `sym_count` port exists.
  - It increments by 1 on each `out_valid && out_ready` and wraps at 16'hFFFF→0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan

- `in_data=32'h0000_0000`, `in_len=3` → one symbol 0; `out_valid` in cycle 5 after the handshake; `busy` low afterwards.
- `in_data=32'h53D0_0000`, `in_len=12`, `out_ready=1` → symbols 2, 5, 13 in order; no further `out_valid`.
- Spanning code: word `32'hC000_0000` with len 2, then `32'hE000_0000` with len 3 → single symbol 15; also a len-0 word inserted between them → same result.
- Backpressure: stream of 8 symbols with `out_ready=0` for 10 cycles → `out_sym` held stable, all 8 symbols delivered in order. Push 4 more words while stalled → `in_ready` low with `fifo_level=4`.
- Reset after 2 bits of `11abc` → all outputs at reset values; next word `32'h0000_0000` with len 3 → symbol 0.
- With `HUFF_FRONT_STATS_EN`: after the 3-symbol test, `sym_count=3`; after reset, `sym_count=0`.

Source files
------------

// File: rtl/huff_stream_front.sv
// huff_stream_front
//
// Bit-stream front end for the Huffman decode path. MSB-aligned code words
// of up to WORD_W bits (with a per-word valid length) are accepted through a
// valid/ready handshake and held in a small word FIFO. A serialiser shifts
// them out at one bit per cycle into a prefix decoder that emits 4-bit symbols
// through an output register with backpressure.
//
// Prefix code (first bit on the left):
//   0ab    -> symbol ab        (0..3)
//   10ab   -> symbol 4 + ab    (4..7)
//   11abc  -> symbol 8 + abc   (8..15)
// Codes may span word boundaries and FIFO-empty gaps.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid, once raised, is held with stable data until the
// transfer; ready may change freely and does not depend on valid.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_data      code bits, first bit in in_data[WORD_W-1]
//   in_len       valid bits in in_data (clamped to WORD_W)
//   in_valid     input word present
//   in_ready     FIFO can accept a word (low while rst is high)
//   out_sym      decoded symbol
//   out_valid    out_sym valid
//   out_ready    consumer accepts the symbol
//   fifo_level   words held in the FIFO, 0..FIFO_DEPTH
//   busy         any word, bit, partial code or symbol still in flight
//   sym_count    symbols delivered, wraps at 16 bits
//                (only with HUFF_FRONT_STATS_EN defined)
//
// Optional feature macro: HUFF_FRONT_STATS_EN adds the sym_count port.

module huff_stream_front #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int LEN_W     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        out_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  fifo_level,
  output logic              busy
`ifdef HUFF_FRONT_STATS_EN
  ,
  output logic [15:0]       sym_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LEN_W-1:0] FULL_LVL = LEN_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] WORD_LEN = LEN_W'(WORD_W);

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
  logic [LEN_W-1:0]  mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LEN_W-1:0]  level;
  logic [LEN_W-1:0]  len_clamped;
  logic              push;
  logic              pop;

  // Serialiser and decoder state (declared here, used by the FIFO pop logic)
  logic [WORD_W-1:0] sr_data;
  logic [LEN_W-1:0]  sr_cnt;
  logic              consume;
  logic              last_bit;

  assign len_clamped = (in_len > WORD_LEN) ? WORD_LEN : in_len;
  assign in_ready    = !rst && (level != FULL_LVL);
  assign push        = in_valid && in_ready;
  // The head is taken either when the serialiser is empty or at the edge
  // where its final bit goes out, so consecutive words have no bubble. A
  // zero-length head is simply loaded as an empty serialiser.
  assign pop         = (level != '0) && ((sr_cnt == '0) || last_bit);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_len[wr_ptr]  <= len_clamped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign fifo_level = level;

  // ---------------------------------------------------------------------------
  // Serialiser: current bit is always sr_data[WORD_W-1]
  // ---------------------------------------------------------------------------
  assign consume  = (sr_cnt != '0) && (!out_valid || out_ready);
  assign last_bit = consume && (sr_cnt == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_data <= '0;
      sr_cnt  <= '0;
    end else if (pop) begin
      sr_data <= mem_data[rd_ptr];
      sr_cnt  <= mem_len[rd_ptr];
    end else if (consume) begin
      sr_data <= {sr_data[WORD_W-2:0], 1'b0};
      sr_cnt  <= sr_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // Only four bits ever need to be stored: the fifth bit of an 11abc code is
  // the one arriving this cycle, so completion is judged on acc_shift.
  // ---------------------------------------------------------------------------
  logic [3:0] acc;
  logic [2:0] acc_cnt;
  logic [4:0] acc_shift;
  logic [2:0] cnt_inc;
  logic       code_done;
  logic [3:0] dec_sym;

  always_comb begin
    acc_shift = {acc, sr_data[WORD_W-1]};
    cnt_inc   = acc_cnt + 3'd1;
    code_done = 1'b0;
    dec_sym   = 4'd0;
    if (consume) begin
      case (cnt_inc)
        3'd3: if (!acc_shift[2]) begin
          code_done = 1'b1;
          dec_sym   = {2'b00, acc_shift[1:0]};
        end
        3'd4: if (acc_shift[3:2] == 2'b10) begin
          code_done = 1'b1;
          dec_sym   = {2'b01, acc_shift[1:0]};
        end
        3'd5: if (acc_shift[4:3] == 2'b11) begin
          code_done = 1'b1;
          dec_sym   = {1'b1, acc_shift[2:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (consume) begin
      if (code_done) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc_shift[3:0];
        acc_cnt <= cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A completion only happens when the register is free
  // (consume already requires it), so out_sym never changes while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sym   <= 4'd0;
      out_valid <= 1'b0;
    end else if (code_done) begin
      out_sym   <= dec_sym;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (level != '0) || (sr_cnt != '0) || (acc_cnt != 3'd0) || out_valid;

`ifdef HUFF_FRONT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      sym_count <= sym_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huff_stream_front.sv
module tb_huff_stream_front;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_sym;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  fifo_level;
  logic        busy;
`ifdef HUFF_FRONT_STATS_EN
  logic [15:0] sym_count;
`endif

  always #5 clk = ~clk;

  huff_stream_front #(.WORD_W(32), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_sym    (out_sym),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .busy       (busy)
`ifdef HUFF_FRONT_STATS_EN
    ,
    .sym_count  (sym_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         applied = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  int         exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every accepted symbol must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sym", {28'd0, out_sym}, 32'hFFFF_FFFF);
      end else begin
        check("sym_order", {28'd0, out_sym}, {28'd0, exp_q.pop_front()});
        exp_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_exp(input int n, input logic [31:0] syms);
    for (int i = 0; i < n; i++) exp_q.push_back(syms[31-4*i -: 4]);
  endtask

  task automatic push_word(input logic [31:0] d, input logic [5:0] l);
    int guard;
    @(posedge clk);
    #1;
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        check("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      guard++;
      if (guard > budget) begin
        check("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    check("drained", exp_q.size(), 32'd0);
`ifdef HUFF_FRONT_STATS_EN
    check("sym_count", {16'd0, sym_count}, exp_cnt);
`endif
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sym", {28'd0, out_sym}, 32'd0);
    check("rst_fifo_level", {26'd0, fifo_level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef HUFF_FRONT_STATS_EN
    check("rst_sym_count", {16'd0, sym_count}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt  = 0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one word each, expected symbols packed first-in-[31:28]
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    int          n_sym;
    logic [31:0] syms;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;

    vecs[0] = '{32'h0000_0000, 6'd3,  1, 32'h0000_0000}; // 000 -> 0
    vecs[1] = '{32'h53D0_0000, 6'd12, 3, 32'h25D0_0000}; // 010|1001|11101
    vecs[2] = '{32'hF800_0000, 6'd5,  1, 32'hF000_0000}; // 11111 -> 15
    vecs[3] = '{32'hB000_0000, 6'd4,  1, 32'h7000_0000}; // 1011 -> 7
    vecs[4] = '{32'h8888_8888, 6'd63, 8, 32'h4444_4444}; // len clamped to 32
    vecs[5] = '{32'hAAAA_AAAA, 6'd32, 8, 32'h6666_6666}; // full word of 1010
    vecs[6] = '{32'hC7FF_FFFF, 6'd5,  1, 32'h8000_0000}; // bits past len ignored
    vecs[7] = '{32'h7920_0000, 6'd11, 3, 32'h3910_0000}; // 011|11001|001

    // Reset held from time 0
    repeat (3) @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: handshake in cycle 0, out_valid expected in cycle 5
    push_exp(1, 32'h0000_0000);
    @(posedge clk);
    #1;
    in_data  = 32'h0000_0000;
    in_len   = 6'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check("latency_3bit", lat, 32'd5);
    wait_idle(50);
    check("busy_after", {31'd0, busy}, 32'd0);

    // Table-driven words
    for (int v = 0; v < 8; v++) begin
      push_exp(vecs[v].n_sym, vecs[v].syms);
      push_word(vecs[v].data, vecs[v].len);
      wait_idle(200);
    end

    // Code spanning two words, then with a zero-length word in between
    push_exp(1, 32'hF000_0000);
    push_word(32'hC000_0000, 6'd2);
    push_word(32'hE000_0000, 6'd3);
    wait_idle(50);
    push_exp(1, 32'hF000_0000);
    push_word(32'hC000_0000, 6'd2);
    push_word(32'h0000_0000, 6'd0);
    push_word(32'hE000_0000, 6'd3);
    wait_idle(50);

    // Partial code survives a FIFO-empty gap
    push_exp(1, 32'hF000_0000);
    push_word(32'hC000_0000, 6'd2);
    repeat (10) @(negedge clk);
    check("gap_busy", {31'd0, busy}, 32'd1);
    check("gap_no_valid", {31'd0, out_valid}, 32'd0);
    push_word(32'hE000_0000, 6'd3);
    wait_idle(50);

    // Backpressure: symbols 0..7 in one word, consumer stalled
    out_ready = 1'b0;
    push_exp(8, 32'h0123_4567);
    push_word(32'h0538_9AB0, 6'd28);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("stall_first_valid", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_sym", {28'd0, out_sym}, 32'd0);
    end
    // Fill the FIFO while the serialiser is stalled
    push_exp(4, 32'h8F1C_0000);
    push_word(32'hC000_0000, 6'd5);  // 8
    push_word(32'hF800_0000, 6'd5);  // 15
    push_word(32'h2000_0000, 6'd3);  // 1
    push_word(32'hE000_0000, 6'd5);  // 12
    @(negedge clk);
    check("full_level", {26'd0, fifo_level}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    // Offer a fifth word while full: it must not be taken
    @(posedge clk);
    #1;
    in_data  = 32'h0000_0000;
    in_len   = 6'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_hold_level", {26'd0, fifo_level}, 32'd4);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(300);

    // Reset after 2 bits of an 11abc code
    push_word(32'hC000_0000, 6'd2);
    repeat (6) @(negedge clk);
    check("midcode_busy", {31'd0, busy}, 32'd1);
    do_reset();
    push_exp(1, 32'h0000_0000);
    push_word(32'h0000_0000, 6'd3);
    wait_idle(50);

`ifdef HUFF_FRONT_STATS_EN
    // Three-symbol word from a fresh reset
    do_reset();
    push_exp(3, 32'h25D0_0000);
    push_word(32'h53D0_0000, 6'd12);
    wait_idle(100);
    check("sym_count_3", {16'd0, sym_count}, 32'd3);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Absolute time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
